rx_fifo: RTL and testbench

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/rx_fifo.sv | 105 ++++++++++
 tb/tb_rx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// Serial frame receiver (start, 8 data LSB first, parity, stop) feeding a
// parity-tagged receive FIFO with a single-cycle read-data pulse interface.
module rx_fifo #(
    parameter int FIFO_WIDTH_R = 9,
    parameter int FIFO_DEPTH_R = 16
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       RxFF,
    output logic       RxFE,
    output logic       Rx_ready,
    output logic [1:0] state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH_R);
    localparam int CW = AW + 1;

    // Handshake: a read is accepted on any rising edge where rd_en is high and
    // the FIFO holds at least one entry; data_valid follows for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              bit_idx;
    logic [FIFO_WIDTH_R-1:0] shreg;
    logic [FIFO_WIDTH_R-1:0] mem [FIFO_DEPTH_R];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;

    logic full, wr_ok, rd_ok, ovf_ev, ferr_ev;

    assign full     = (count == CW'(FIFO_DEPTH_R));
    assign RxFF     = full;
    assign RxFE     = (count == '0);
    assign Rx_ready = ~full;
    assign state_dbg = state;

    // A full FIFO drops the frame even if a read frees a slot on the same edge.
    assign wr_ok   = (state == STOP) && data_in && !full;
    assign ovf_ev  = (state == STOP) && data_in && full;
    assign ferr_ev = (state == STOP) && !data_in;
    assign rd_ok   = rd_en && (count != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!data_in) state_nxt = DATA;
            DATA:    if (bit_idx == 4'(FIFO_WIDTH_R - 1)) state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_idx    <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_idx    <= (state == DATA) ? bit_idx + 4'd1 : 4'd0;
            frame_err  <= ferr_ev;
            overflow   <= ovf_ev;
            data_valid <= rd_ok;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr     <= rd_ptr + 1'b1;
                data_out   <= mem[rd_ptr][7:0];
                parity_err <= ^mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // LSB arrives first, so shifting in from the top leaves parity in the MSB.
    always_ff @(posedge baud_clk) begin
        if (state == DATA) shreg <= {data_in, shreg[FIFO_WIDTH_R-1:1]};
    end

    always_ff @(posedge baud_clk) begin
        if (rst && wr_ok) mem[wr_ptr] <= shreg;
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: directed scenarios plus random frames, checked every
// cycle against a queue-based model of the FIFO contents.
module tb_rx_fifo;

    localparam int DEPTH = 16;

    logic       baud_clk = 1'b0;
    logic       rst, data_in, rd_en;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, overflow;
    logic       RxFF, RxFE, Rx_ready;
    logic [1:0] state_dbg;

    always #5 baud_clk = ~baud_clk;

    rx_fifo #(.FIFO_WIDTH_R(9), .FIFO_DEPTH_R(DEPTH)) dut (
        .baud_clk   (baud_clk),
        .rst        (rst),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .RxFF       (RxFF),
        .RxFE       (RxFE),
        .Rx_ready   (Rx_ready),
        .state_dbg  (state_dbg)
    );

    // Driver marks the cycle whose edge samples a stop bit, with the frame it closes.
    logic       stop_flag;
    logic [8:0] stop_ent;
    logic       chk_en;

    logic [8:0] exp_q[$];
    logic [7:0] m_data;
    logic       m_dv, m_perr, m_ferr, m_ovf;
    int         m_pre;
    logic [8:0] m_e;

    always @(posedge baud_clk) begin
        if (!rst) begin
            exp_q.delete();
            m_data = 8'h00;
            m_dv   = 1'b0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_pre  = exp_q.size();
            m_ferr = stop_flag && !data_in;
            m_ovf  = stop_flag && data_in && (m_pre == DEPTH);
            if (rd_en && m_pre > 0) begin
                m_e    = exp_q.pop_front();
                m_data = m_e[7:0];
                m_perr = ^m_e;
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (stop_flag && data_in && m_pre < DEPTH) exp_q.push_back(stop_ent);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk1("data_valid", data_valid, m_dv);
        chk8("data_out",   data_out,   m_data);
        chk1("parity_err", parity_err, m_perr);
        chk1("frame_err",  frame_err,  m_ferr);
        chk1("overflow",   overflow,   m_ovf);
        chk1("RxFF",       RxFF,       exp_q.size() == DEPTH);
        chk1("RxFE",       RxFE,       exp_q.size() == 0);
        chk1("Rx_ready",   Rx_ready,   exp_q.size() != DEPTH);
    endtask

    task automatic step(input logic din, input logic rd, input logic stp, input logic [8:0] ent);
        @(negedge baud_clk);
        if (chk_en) compare_all();
        data_in   = din;
        rd_en     = rd;
        stop_flag = stp;
        stop_ent  = ent;
    endtask

    function automatic logic rd_pick(input int unsigned pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic idle(input int n, input int unsigned pct);
        repeat (n) step(1'b1, rd_pick(pct), 1'b0, 9'h0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                              input int unsigned pct, input logic stop_rd);
        step(1'b0, rd_pick(pct), 1'b0, 9'h0);
        for (int i = 0; i < 8; i++) step(b[i], rd_pick(pct), 1'b0, 9'h0);
        step(p, rd_pick(pct), 1'b0, 9'h0);
        step(s, stop_rd, 1'b1, {p, b});
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_RxFE"},     RxFE,       1'b1);
        chk1({tag, "_RxFF"},     RxFF,       1'b0);
        chk1({tag, "_Rx_ready"}, Rx_ready,   1'b1);
        chk8({tag, "_data_out"}, data_out,   8'h00);
        chk1({tag, "_dv"},       data_valid, 1'b0);
        chk1({tag, "_perr"},     parity_err, 1'b0);
        chk1({tag, "_ferr"},     frame_err,  1'b0);
        chk1({tag, "_ovf"},      overflow,   1'b0);
    endtask

    logic [7:0] b;
    logic       p, s;
    logic [7:0] sim_exp [3];

    initial begin
        rst = 1'b0; data_in = 1'b1; rd_en = 1'b0;
        stop_flag = 1'b0; stop_ent = 9'h0; chk_en = 1'b0;
        step(1'b1, 1'b0, 1'b0, 9'h0);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        check_reset_values("reset");
        chk_en = 1'b1;
        rst = 1'b1;
        idle(2, 0);

        // Single frame A5 with good parity
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        idle(1, 0);
        chk1("single_RxFE_after_write", RxFE, 1'b0);
        step(1'b1, 1'b1, 1'b0, 9'h0);
        chk1("single_dv_before", data_valid, 1'b0);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk1("single_dv", data_valid, 1'b1);
        chk8("single_data", data_out, 8'hA5);
        chk1("single_perr", parity_err, 1'b0);
        chk1("single_RxFE_after_read", RxFE, 1'b1);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk1("single_dv_drop", data_valid, 1'b0);

        // Parity error: 8'h01 with parity bit 0
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
        idle(1, 0);
        step(1'b1, 1'b1, 1'b0, 9'h0);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk8("parity_data", data_out, 8'h01);
        chk1("parity_perr", parity_err, 1'b1);

        // Bad stop bit
        send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk1("badstop_ferr", frame_err, 1'b1);
        chk1("badstop_RxFE", RxFE, 1'b1);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk1("badstop_ferr_drop", frame_err, 1'b0);

        // Fill to full, overflow, then drain in order across the pointer wrap
        for (int i = 0; i < 16; i++) send_frame(8'(i), ^(8'(i)), 1'b1, 0, 1'b0);
        idle(1, 0);
        chk1("full_RxFF", RxFF, 1'b1);
        chk1("full_Rx_ready", Rx_ready, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 0, 1'b1);
        idle(1, 0);
        chk1("full_overflow", overflow, 1'b1);
        chk8("full_stop_read", data_out, 8'h00);
        idle(1, 0);
        chk1("full_overflow_drop", overflow, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i < 15, 1'b0, 9'h0);
            if (i > 0) chk8("drain_data", data_out, 8'(i));
        end
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk8("drain_last", data_out, 8'h0F);
        chk1("drain_RxFE", RxFE, 1'b1);

        // Simultaneous write and read with three entries held
        send_frame(8'h11, ^(8'h11), 1'b1, 0, 1'b0);
        send_frame(8'h22, ^(8'h22), 1'b1, 0, 1'b0);
        send_frame(8'h33, ^(8'h33), 1'b1, 0, 1'b0);
        send_frame(8'h44, ^(8'h44), 1'b1, 0, 1'b1);
        idle(1, 0);
        chk1("simul_dv", data_valid, 1'b1);
        chk8("simul_oldest", data_out, 8'h11);
        sim_exp[0] = 8'h22; sim_exp[1] = 8'h33; sim_exp[2] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i < 3, 1'b0, 9'h0);
            if (i > 0) chk8("simul_rest", data_out, sim_exp[i-1]);
        end
        chk1("simul_RxFE", RxFE, 1'b1);

        // Reset during data bit 4, with an entry already stored
        send_frame(8'h99, ^(8'h99), 1'b1, 0, 1'b0);
        b = 8'h77;
        step(1'b0, 1'b0, 1'b0, 9'h0);
        for (int i = 0; i < 5; i++) step(b[i], 1'b0, 1'b0, 9'h0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 9'h0);
        check_reset_values("midreset");
        rst = 1'b1;
        idle(2, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        idle(1, 0);
        step(1'b1, 1'b1, 1'b0, 9'h0);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk8("post_reset_data", data_out, 8'h3C);
        chk1("post_reset_perr", parity_err, 1'b0);
        chk1("post_reset_RxFE", RxFE, 1'b1);

        // Random frames: slow reads first to provoke overflow, then heavy reads
        for (int n = 0; n < 400; n++) begin
            int unsigned pct;
            pct = (n < 200) ? 5 : 40;
            idle($urandom_range(0, 2), pct);
            b = 8'($urandom());
            p = ($urandom_range(0, 7) == 0) ? ~^b : ^b;
            s = ($urandom_range(0, 15) != 0);
            send_frame(b, p, s, pct, rd_pick(pct));
        end
        idle(40, 100);
        step(1'b1, 1'b0, 1'b0, 9'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
